instruction_fetch_queue: RTL and testbench

Sequencer that drives the program memory's byte address and buffers fetched instructions in a small prefetch FIFO for the core. It owns the fetch PC, issues one sequential fetch per cycle while space exists, and flushes/re-targets on a redirect (branch, jump, trap). It sits between the combinational-read program memory and the decode stage, decoupling core stalls from fetch.

---
 rtl/instruction_fetch_queue_if.sv | 30 +++
 rtl/instruction_fetch_queue.sv | 92 +++++++++
 tb/tb_instruction_fetch_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: program-memory address/data, redirect request and the
// decode-side head-of-queue view.
interface instruction_fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] Mem_Address_o;
  logic [DATA_WIDTH-1:0] Mem_Instruction_i;
  logic                  Redirect_i;
  logic [DATA_WIDTH-1:0] Redirect_PC_i;
  logic                  Pop_i;
  logic                  Valid_o;
  logic [DATA_WIDTH-1:0] Instruction_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [CW-1:0]         Count_o;

  // Driven by the core / program memory side.
  modport master (
    input  Mem_Address_o, Valid_o, Instruction_o, PC_o, Count_o,
    output Mem_Instruction_i, Redirect_i, Redirect_PC_i, Pop_i
  );

  // Implemented by the fetch queue.
  modport slave (
    output Mem_Address_o, Valid_o, Instruction_o, PC_o, Count_o,
    input  Mem_Instruction_i, Redirect_i, Redirect_PC_i, Pop_i
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch PC sequencer plus a DEPTH-entry prefetch FIFO of {pc, instr} between
// a combinational-read program memory and decode; redirects flush and re-target.
module instruction_fetch_queue #(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input logic                     clk,
  input logic                     reset,
  instruction_fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_d    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_d [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  valid;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  unused_redirect_lsbs;

  assign valid                = (count_q != '0);
  assign full                 = (count_q == CW'(DEPTH));
  assign pop                  = bus.Pop_i & valid;
  // A pop in the same cycle frees the slot, so a full queue still fetches.
  assign push                 = ~bus.Redirect_i & (~full | pop);
  assign redirect_target      = {bus.Redirect_PC_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.Redirect_PC_i[1:0];

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (bus.Redirect_i) begin
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = bus.Mem_Instruction_i;
        wr_ptr_d              = wr_ptr_q + AW'(1);
        fetch_pc_d            = fetch_pc_q + DATA_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign bus.Mem_Address_o = fetch_pc_q;
  assign bus.Valid_o       = valid;
  assign bus.Instruction_o = instr_mem_q[rd_ptr_q];
  assign bus.PC_o          = pc_mem_q[rd_ptr_q];
  assign bus.Count_o       = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: fill/hold, streaming, redirects,
// address wrap and mid-stream reset, against hand-computed values.
module tb_instruction_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  instruction_fetch_queue_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  instruction_fetch_queue #(
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0040_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ROM: word i above RESET_PC holds 0x1000_0000 + i.
  assign bus.Mem_Instruction_i = 32'h1000_0000 + ((bus.Mem_Address_o - 32'h0040_0000) >> 2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_cnt [6];
    exp_cnt = '{1, 2, 3, 4, 4, 4};

    reset             = 1'b0;
    bus.Redirect_i    = 1'b0;
    bus.Redirect_PC_i = '0;
    bus.Pop_i         = 1'b0;

    // Reset values
    do_reset();
    check("rst_count", 32'(bus.Count_o), 0);
    check("rst_valid", 32'(bus.Valid_o), 0);
    check("rst_instr", bus.Instruction_o, 0);
    check("rst_pc",    bus.PC_o, 0);
    check("rst_addr",  bus.Mem_Address_o, 32'h0040_0000);

    // Fill with no pops: count ramps and saturates, fetch address holds
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("fill_count%0d", i), 32'(bus.Count_o), exp_cnt[i]);
      check($sformatf("fill_addr%0d", i), bus.Mem_Address_o,
            32'h0040_0000 + 4 * ((i < 3) ? (i + 1) : 4));
    end
    check("fill_pc",    bus.PC_o, 32'h0040_0000);
    check("fill_instr", bus.Instruction_o, 32'h1000_0000);
    check("fill_valid", 32'(bus.Valid_o), 1);

    // Full queue, one pop: simultaneous push/pop
    bus.Pop_i = 1'b1;
    step();
    bus.Pop_i = 1'b0;
    check("fullpop_count", 32'(bus.Count_o), 4);
    check("fullpop_pc",    bus.PC_o, 32'h0040_0004);
    check("fullpop_instr", bus.Instruction_o, 32'h1000_0001);
    check("fullpop_addr",  bus.Mem_Address_o, 32'h0040_0014);

    // Streaming with Pop held high from reset release
    do_reset();
    bus.Pop_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stream_pc%0d", i),    bus.PC_o, 32'h0040_0000 + 4 * i);
      check($sformatf("stream_instr%0d", i), bus.Instruction_o, 32'h1000_0000 + i);
      check($sformatf("stream_count%0d", i), 32'(bus.Count_o), 1);
    end
    bus.Pop_i = 1'b0;

    // Redirect with 3 entries queued and Pop high
    do_reset();
    step(); step(); step();
    check("pre_redir_count", 32'(bus.Count_o), 3);
    bus.Redirect_i    = 1'b1;
    bus.Redirect_PC_i = 32'h0040_0103;
    bus.Pop_i         = 1'b1;
    step();
    bus.Redirect_i = 1'b0;
    bus.Pop_i      = 1'b0;
    check("redir_valid", 32'(bus.Valid_o), 0);
    check("redir_count", 32'(bus.Count_o), 0);
    check("redir_addr",  bus.Mem_Address_o, 32'h0040_0100);
    step();
    check("redir_head_valid", 32'(bus.Valid_o), 1);
    check("redir_head_pc",    bus.PC_o, 32'h0040_0100);
    check("redir_head_instr", bus.Instruction_o, 32'h1000_0040);
    check("redir_head_count", 32'(bus.Count_o), 1);

    // Redirect near top of address space: PC wraps to zero
    bus.Redirect_i    = 1'b1;
    bus.Redirect_PC_i = 32'hFFFF_FFF8;
    step();
    bus.Redirect_i = 1'b0;
    bus.Pop_i      = 1'b1;
    step();
    check("wrap_pc0", bus.PC_o, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", bus.PC_o, 32'hFFFF_FFFC);
    check("wrap_addr", bus.Mem_Address_o, 32'h0000_0000);
    step();
    check("wrap_pc2", bus.PC_o, 32'h0000_0000);
    bus.Pop_i = 1'b0;

    // Back-to-back redirects: only the last target is fetched
    bus.Redirect_i    = 1'b1;
    bus.Redirect_PC_i = 32'h0000_2000;
    step();
    bus.Redirect_PC_i = 32'h0000_3004;
    step();
    bus.Redirect_i = 1'b0;
    check("b2b_valid", 32'(bus.Valid_o), 0);
    check("b2b_addr",  bus.Mem_Address_o, 32'h0000_3004);
    step();
    check("b2b_pc",    bus.PC_o, 32'h0000_3004);
    check("b2b_count", 32'(bus.Count_o), 1);

    // Reset mid-stream with a redirect pending
    do_reset();
    step(); step();
    check("mid_pre_count", 32'(bus.Count_o), 2);
    reset             = 1'b0;
    bus.Redirect_i    = 1'b1;
    bus.Redirect_PC_i = 32'h0000_8000;
    step();
    check("mid_count", 32'(bus.Count_o), 0);
    check("mid_valid", 32'(bus.Valid_o), 0);
    check("mid_instr", bus.Instruction_o, 0);
    check("mid_pc",    bus.PC_o, 0);
    check("mid_addr",  bus.Mem_Address_o, 32'h0040_0000);
    bus.Redirect_i = 1'b0;
    reset          = 1'b1;
    step();
    check("post_rst_pc",    bus.PC_o, 32'h0040_0000);
    check("post_rst_valid", 32'(bus.Valid_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
